// File: rtl/pulse_width_decoder_if.sv
// rtl/pulse_width_decoder_if.sv - serial line input and decoded event outputs of the pulse width decoder
interface pulse_width_decoder_if #(
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
);
    logic             entrada;
    logic             contador_clr;
    logic             saida;
    logic             erro;
    logic [2:0]       estado_atual;
    logic [LEN_W-1:0] comprimento;
    logic [CNT_W-1:0] valid_cnt;
    logic [CNT_W-1:0] err_cnt;

    modport master (
        output entrada,
        output contador_clr,
        input  saida,
        input  erro,
        input  estado_atual,
        input  comprimento,
        input  valid_cnt,
        input  err_cnt
    );

    modport slave (
        input  entrada,
        input  contador_clr,
        output saida,
        output erro,
        output estado_atual,
        output comprimento,
        output valid_cnt,
        output err_cnt
    );
endinterface

// File: rtl/pulse_width_decoder.sv
// rtl/pulse_width_decoder.sv - measures high-run widths on a serial line and flags good and bad runs
module pulse_width_decoder #(
    parameter int PULSE_LEN = 3,
    parameter int LEN_W     = 4,
    parameter int CNT_W     = 8
) (
    input logic                  clock,
    input logic                  reset,
    pulse_width_decoder_if.slave bus
);

    typedef enum logic [2:0] {
        SYNC    = 3'd0,
        IDLE    = 3'd1,
        MEASURE = 3'd2,
        VALID   = 3'd3,
        ERROR   = 3'd4
    } state_t;

    localparam logic [LEN_W-1:0] RUN_MAX    = {LEN_W{1'b1}};
    localparam logic [LEN_W-1:0] RUN_TARGET = LEN_W'(PULSE_LEN);
    localparam logic [LEN_W-1:0] RUN_ONE    = LEN_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t           state_q, state_d;
    logic [LEN_W-1:0] run_q, run_d;
    logic [LEN_W-1:0] comprimento_q, comprimento_d;
    logic             saida_q, saida_d;
    logic             erro_q, erro_d;
    logic [CNT_W-1:0] valid_cnt_q, valid_cnt_d;
    logic [CNT_W-1:0] err_cnt_q, err_cnt_d;

    // Next state, run length and latched width of the run just finished
    always_comb begin
        state_d       = SYNC;
        run_d         = run_q;
        comprimento_d = comprimento_q;
        case (state_q)
            SYNC: begin
                // A run already high when we come out of reset is discarded
                run_d   = '0;
                state_d = bus.entrada ? SYNC : IDLE;
            end
            IDLE: begin
                if (bus.entrada) begin
                    state_d = MEASURE;
                    run_d   = RUN_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            MEASURE: begin
                if (bus.entrada) begin
                    state_d = MEASURE;
                    if (run_q != RUN_MAX) begin
                        run_d = run_q + RUN_ONE;
                    end
                end else begin
                    comprimento_d = run_q;
                    state_d       = (run_q == RUN_TARGET) ? VALID : ERROR;
                end
            end
            VALID, ERROR: begin
                // This cycle is the low sample separating runs, so a new run may start right away
                if (bus.entrada) begin
                    state_d = MEASURE;
                    run_d   = RUN_ONE;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = SYNC;
                run_d   = '0;
            end
        endcase
    end

    // Event pulses and saturating event counters; a clear beats a simultaneous count
    always_comb begin
        saida_d     = (state_d == VALID);
        erro_d      = (state_d == ERROR);
        valid_cnt_d = valid_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (bus.contador_clr) begin
            valid_cnt_d = '0;
            err_cnt_d   = '0;
        end else begin
            if (saida_d && (valid_cnt_q != CNT_MAX)) begin
                valid_cnt_d = valid_cnt_q + CNT_ONE;
            end
            if (erro_d && (err_cnt_q != CNT_MAX)) begin
                err_cnt_d = err_cnt_q + CNT_ONE;
            end
        end
    end

    // State and output registers with asynchronous reset
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= SYNC;
            run_q         <= '0;
            comprimento_q <= '0;
            saida_q       <= 1'b0;
            erro_q        <= 1'b0;
            valid_cnt_q   <= '0;
            err_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            run_q         <= run_d;
            comprimento_q <= comprimento_d;
            saida_q       <= saida_d;
            erro_q        <= erro_d;
            valid_cnt_q   <= valid_cnt_d;
            err_cnt_q     <= err_cnt_d;
        end
    end

    assign bus.saida        = saida_q;
    assign bus.erro         = erro_q;
    assign bus.estado_atual = state_q;
    assign bus.comprimento  = comprimento_q;
    assign bus.valid_cnt    = valid_cnt_q;
    assign bus.err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_pulse_width_decoder.sv
// tb/tb_pulse_width_decoder.sv - directed vector bench for pulse_width_decoder
module tb_pulse_width_decoder;

    logic clock;
    logic reset;

    pulse_width_decoder_if #(.LEN_W(4), .CNT_W(8)) bus_a ();
    pulse_width_decoder_if #(.LEN_W(4), .CNT_W(2)) bus_b ();

    assign bus_b.entrada      = bus_a.entrada;
    assign bus_b.contador_clr = bus_a.contador_clr;

    pulse_width_decoder #(.PULSE_LEN(3), .LEN_W(4), .CNT_W(8)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    pulse_width_decoder #(.PULSE_LEN(3), .LEN_W(4), .CNT_W(2)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    initial clock = 1'b1;
    always #5 clock = ~clock;

    typedef struct {
        logic e;
        logic clr;
        int   est;
        int   s;
        int   er;
        int   comp;
        int   v;
        int   ec;
        int   v2;
        int   ec2;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic add(input logic e, input logic clr, input int est, input int s, input int er,
                       input int comp, input int v, input int ec, input int v2, input int ec2);
        vec_t r;
        r.e = e; r.clr = clr; r.est = est; r.s = s; r.er = er;
        r.comp = comp; r.v = v; r.ec = ec; r.v2 = v2; r.ec2 = ec2;
        vecs.push_back(r);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_all(input string tag, input int est, input int s, input int er,
                             input int comp, input int v, input int ec, input int v2, input int ec2);
        check({tag, ".estado"},   32'(bus_a.estado_atual), est);
        check({tag, ".saida"},    32'(bus_a.saida), s);
        check({tag, ".erro"},     32'(bus_a.erro), er);
        check({tag, ".comp"},     32'(bus_a.comprimento), comp);
        check({tag, ".valid"},    32'(bus_a.valid_cnt), v);
        check({tag, ".err"},      32'(bus_a.err_cnt), ec);
        check({tag, ".b_estado"}, 32'(bus_b.estado_atual), est);
        check({tag, ".b_saida"},  32'(bus_b.saida), s);
        check({tag, ".b_erro"},   32'(bus_b.erro), er);
        check({tag, ".b_valid"},  32'(bus_b.valid_cnt), v2);
        check({tag, ".b_err"},    32'(bus_b.err_cnt), ec2);
    endtask

    // Drive inputs just after an edge, then sample 1 ns after the next edge
    task automatic step(input logic e, input logic clr);
        bus_a.entrada      = e;
        bus_a.contador_clr = clr;
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset              = 1'b1;
        bus_a.entrada      = 1'b0;
        bus_a.contador_clr = 1'b0;

        // Clean 3-cycle run: 0 -> 1 -> 2 x3 -> 3 -> 1
        add(0,0, 1,0,0, 0, 0,0, 0,0);
        add(1,0, 2,0,0, 0, 0,0, 0,0);
        add(1,0, 2,0,0, 0, 0,0, 0,0);
        add(1,0, 2,0,0, 0, 0,0, 0,0);
        add(0,0, 3,1,0, 3, 1,0, 1,0);
        add(0,0, 1,0,0, 3, 1,0, 1,0);
        // Clear counters while idle
        add(0,1, 1,0,0, 3, 0,0, 0,0);
        // Bad runs of 1, 2 and 5 cycles
        add(1,0, 2,0,0, 3, 0,0, 0,0);
        add(0,0, 4,0,1, 1, 0,1, 0,1);
        add(0,0, 1,0,0, 1, 0,1, 0,1);
        for (int i = 0; i < 2; i++) add(1,0, 2,0,0, 1, 0,1, 0,1);
        add(0,0, 4,0,1, 2, 0,2, 0,2);
        add(0,0, 1,0,0, 2, 0,2, 0,2);
        for (int i = 0; i < 5; i++) add(1,0, 2,0,0, 2, 0,2, 0,2);
        add(0,0, 4,0,1, 5, 0,3, 0,3);
        add(0,0, 1,0,0, 5, 0,3, 0,3);
        // Back-to-back good runs with a single low cycle between them
        for (int i = 0; i < 3; i++) add(1,0, 2,0,0, 5, 0,3, 0,3);
        add(0,0, 3,1,0, 3, 1,3, 1,3);
        for (int i = 0; i < 3; i++) add(1,0, 2,0,0, 3, 1,3, 1,3);
        add(0,0, 3,1,0, 3, 2,3, 2,3);
        add(0,0, 1,0,0, 3, 2,3, 2,3);
        // Five more good runs: the 2-bit counter sticks at 3
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 3; k++) add(1,0, 2,0,0, 3, 2+i,3, (i == 0) ? 2 : 3, 3);
            add(0,0, 3,1,0, 3, 3+i,3, 3,3);
            add(0,0, 1,0,0, 3, 3+i,3, 3,3);
        end
        // Clear coinciding with entry to VALID: clear wins, saida still pulses
        for (int i = 0; i < 3; i++) add(1,0, 2,0,0, 3, 7,3, 3,3);
        add(0,1, 3,1,0, 3, 0,0, 0,0);
        add(0,0, 1,0,0, 3, 0,0, 0,0);
        // 20-cycle run saturates the run counter and ends in ERROR
        for (int i = 0; i < 20; i++) add(1,0, 2,0,0, 3, 0,0, 0,0);
        add(0,0, 4,0,1, 15, 0,1, 0,1);
        add(0,0, 1,0,0, 15, 0,1, 0,1);

        #15;
        reset = 1'b0;
        #1;
        check_all("reset", 0,0,0, 0, 0,0, 0,0);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].e, vecs[i].clr);
            check_all($sformatf("vec%0d", i), vecs[i].est, vecs[i].s, vecs[i].er,
                      vecs[i].comp, vecs[i].v, vecs[i].ec, vecs[i].v2, vecs[i].ec2);
        end

        // Line held high across reset release: that run is never measured
        reset         = 1'b1;
        bus_a.entrada = 1'b1;
        #1;
        check_all("rst_hold", 0,0,0, 0, 0,0, 0,0);
        @(posedge clock);
        #4;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            check_all($sformatf("sync_hi%0d", i), 0,0,0, 0, 0,0, 0,0);
        end
        step(0, 0);
        check_all("sync_lo", 1,0,0, 0, 0,0, 0,0);
        for (int i = 0; i < 3; i++) begin
            step(1, 0);
            check_all($sformatf("clean_hi%0d", i), 2,0,0, 0, 0,0, 0,0);
        end
        step(0, 0);
        check_all("clean_end", 3,1,0, 3, 1,0, 1,0);
        step(0, 0);
        check_all("clean_idle", 1,0,0, 3, 1,0, 1,0);

        // Asynchronous reset in the middle of a measurement
        step(1, 0);
        step(1, 0);
        check_all("mid_run", 2,0,0, 3, 1,0, 1,0);
        #2;
        reset = 1'b1;
        #1;
        check_all("async_rst", 0,0,0, 0, 0,0, 0,0);
        bus_a.entrada = 1'b0;
        @(posedge clock);
        #2;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            check_all($sformatf("post_rst%0d", i), 1,0,0, 0, 0,0, 0,0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
